// File: rtl/comparator_serial.sv
// comparator_serial
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
// MSB-first, DIGIT bits per clock. The result is reported on registered
// G/L/E flags, and a start/busy/done handshake controls each compare.
// In signed mode the MSB of both operands is flipped when they are captured.
// This offset-binary mapping turns a two's-complement compare into an
// unsigned one, so the digit datapath only ever does unsigned compares.
// With EARLY=1 a compare ends on the first unequal digit. With EARLY=0 every
// compare takes WIDTH/DIGIT cycles, so latency is constant.

module comparator_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter bit EARLY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             L,
  output logic             E
);

  // Number of digit steps per compare, and the counter sized to reach N-1.
  localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // An operand width that does not split into whole digits is a build error.
  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("comparator_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Flips the operand MSB in signed mode so that the remaining datapath can
  // compare the operands as plain unsigned numbers.
  function automatic logic [WIDTH-1:0] to_offset_binary(
    input logic [WIDTH-1:0] value,
    input logic             is_signed
  );
    logic [WIDTH-1:0] msb_mask;
    msb_mask            = '0;
    msb_mask[WIDTH-1]   = is_signed;
    return value ^ msb_mask;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             dec_gt_q;
  logic             done_q;
  logic             g_q;
  logic             l_q;
  logic             e_q;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             dig_neq;
  logic             dig_gt;
  logic             accept;
  logic             finish;
  logic             res_g;
  logic             res_l;
  logic             res_e;

  // The current digit is always the top DIGIT bits of the shift registers.
  assign dig_a = sa_q[WIDTH-1 -: DIGIT];
  assign dig_b = sb_q[WIDTH-1 -: DIGIT];

  // State register; reset returns to IDLE at once and drops any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on start, return to IDLE on the finishing digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = BUSY;
      BUSY:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/decision logic: compare the current digit and decide whether this
  // cycle is the last one. It also forms the result that is loaded at the
  // finish edge.
  always_comb begin
    accept  = 1'b0;
    finish  = 1'b0;
    res_g   = 1'b0;
    res_l   = 1'b0;
    res_e   = 1'b0;
    dig_neq = (dig_a != dig_b);
    dig_gt  = (dig_a > dig_b);
    case (state_q)
      IDLE: begin
        accept = start;
      end
      BUSY: begin
        // A latched decision always wins over later digits. Later digits only
        // matter when no inequality has been seen yet.
        finish = (cnt_q == LAST_CNT) || (EARLY && dig_neq && !decided_q);
        if (decided_q) begin
          res_g = dec_gt_q;
          res_l = !dec_gt_q;
        end else if (dig_neq) begin
          res_g = dig_gt;
          res_l = !dig_gt;
        end else begin
          res_e = 1'b1;
        end
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  // Operand shift registers: load the mapped operands on accept, then step
  // one digit per BUSY cycle. These hold data only, so they have no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q <= to_offset_binary(A, signed_mode);
      sb_q <= to_offset_binary(B, signed_mode);
    end else if (state_q == BUSY) begin
      sa_q <= sa_q << DIGIT;
      sb_q <= sb_q << DIGIT;
    end
  end

  // Digit counter and latched first-inequality decision for the compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
    end else if (state_q == BUSY) begin
      if (!finish) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (dig_neq && !decided_q) begin
        decided_q <= 1'b1;
        dec_gt_q  <= dig_gt;
      end
    end
  end

  // Result flags and the done pulse. The flags change only on a finish edge,
  // so they hold across a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      g_q    <= 1'b0;
      l_q    <= 1'b0;
      e_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        g_q <= res_g;
        l_q <= res_l;
        e_q <= res_e;
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign G    = g_q;
  assign L    = l_q;
  assign E    = e_q;

endmodule

// File: tb/tb_comparator_serial.sv
// tb_comparator_serial
// Drives five comparator_serial instances (WIDTH=16) with different DIGIT and
// EARLY settings. Fixed vectors and corner sequences are checked against
// hand-derived results. Random operands are checked against a behavioural
// model that compares the operands as integers and derives the latency from
// the position of the first differing bit.

module tb_comparator_serial;

  // Instance settings: index -> DIGIT, EARLY
  localparam int DIG [5] = '{4, 4, 1, 2, 16};
  localparam bit EAR [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  start_v;
  logic [4:0]  sm_v;
  logic [15:0] a_v [5];
  logic [15:0] b_v [5];
  logic [4:0]  busy_v, done_v, g_v, l_v, e_v;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  comparator_serial #(.WIDTH(16), .DIGIT(4), .EARLY(1'b1)) u_d4_e1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]), .A(a_v[0]), .B(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .G(g_v[0]), .L(l_v[0]), .E(e_v[0]));
  comparator_serial #(.WIDTH(16), .DIGIT(4), .EARLY(1'b0)) u_d4_e0 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]), .A(a_v[1]), .B(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .G(g_v[1]), .L(l_v[1]), .E(e_v[1]));
  comparator_serial #(.WIDTH(16), .DIGIT(1), .EARLY(1'b1)) u_d1_e1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]), .A(a_v[2]), .B(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .G(g_v[2]), .L(l_v[2]), .E(e_v[2]));
  comparator_serial #(.WIDTH(16), .DIGIT(2), .EARLY(1'b0)) u_d2_e0 (
    .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm_v[3]), .A(a_v[3]), .B(b_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .G(g_v[3]), .L(l_v[3]), .E(e_v[3]));
  comparator_serial #(.WIDTH(16), .DIGIT(16), .EARLY(1'b1)) u_d16_e1 (
    .clk(clk), .rst(rst), .start(start_v[4]), .signed_mode(sm_v[4]), .A(a_v[4]), .B(b_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .G(g_v[4]), .L(l_v[4]), .E(e_v[4]));

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  gle;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gle_of(input int idx);
    return {g_v[idx], l_v[idx], e_v[idx]};
  endfunction

  // Reference: integer compare of the operands; latency from the first differing bit.
  function automatic void model(input int idx, input logic [15:0] a, input logic [15:0] b,
                                input logic sm, output logic [2:0] gle, output int lat);
    logic signed [16:0] ea, eb;
    logic [15:0] x;
    int p;
    int n;
    ea = sm ? {a[15], a} : {1'b0, a};
    eb = sm ? {b[15], b} : {1'b0, b};
    if (ea > eb)      gle = 3'b100;
    else if (ea < eb) gle = 3'b010;
    else              gle = 3'b001;
    n = 16 / DIG[idx];
    x = a ^ b;
    p = -1;
    for (int i = 0; i < 16; i++) if (x[i]) p = i;
    if (!EAR[idx] || p < 0) lat = n;
    else                    lat = (15 - p) / DIG[idx] + 1;
  endfunction

  // One compare with a one-cycle start pulse. Returns the flags and the
  // number of edges from the accepting edge to the done edge.
  task automatic do_compare(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input logic sm, output logic [2:0] gle, output int lat);
    bit got;
    @(negedge clk);
    a_v[idx] = a; b_v[idx] = b; sm_v[idx] = sm; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("busy_at_accept[%0d]", idx), int'(busy_v[idx]), 1);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); sm_v[idx] = 1'($urandom);
    lat = -1;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done_v[idx]) begin
        got = 1'b1;
        lat = k;
      end else begin
        check($sformatf("busy_during[%0d]", idx), int'(busy_v[idx]), 1);
      end
    end
    gle = gle_of(idx);
    if (!got) begin
      check($sformatf("done_timeout[%0d]", idx), 0, 1);
    end else begin
      check($sformatf("busy_at_done[%0d]", idx), int'(busy_v[idx]), 0);
      @(posedge clk); #1;
      check($sformatf("done_one_cycle[%0d]", idx), int'(done_v[idx]), 0);
      check($sformatf("gle_hold[%0d]", idx), int'(gle_of(idx)), int'(gle));
    end
  endtask

  // start held high with new operands every cycle; only accepted values count.
  task automatic handshake(input int idx, input logic [2:0] last_in);
    logic [2:0] last, exp_gle;
    int accept, exp_done, ops, m;
    logic [15:0] ra, rb;
    logic rs;
    last = last_in;
    accept = 0; exp_done = -1; ops = 0; exp_gle = 3'b000;
    for (int cyc = 0; cyc < 300 && ops < 6; cyc++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : (ra ^ (16'h1 << $urandom_range(0, 15)));
      rs = 1'($urandom);
      a_v[idx] = ra; b_v[idx] = rb; sm_v[idx] = rs; start_v[idx] = 1'b1;
      @(posedge clk); #1;
      if (cyc == accept) begin
        model(idx, ra, rb, rs, exp_gle, m);
        exp_done = cyc + m;
        check($sformatf("hs_busy[%0d]", idx), int'(busy_v[idx]), 1);
      end
      if (cyc == exp_done) begin
        check($sformatf("hs_done[%0d]", idx), int'(done_v[idx]), 1);
        check($sformatf("hs_gle[%0d]", idx), int'(gle_of(idx)), int'(exp_gle));
        last = exp_gle;
        accept = cyc + 1;
        ops++;
      end else begin
        check($sformatf("hs_no_done[%0d]", idx), int'(done_v[idx]), 0);
        check($sformatf("hs_gle_hold[%0d]", idx), int'(gle_of(idx)), int'(last));
      end
    end
    start_v[idx] = 1'b0;
    check($sformatf("hs_ops[%0d]", idx), ops, 6);
  endtask

  initial begin
    logic [2:0] gle, exp_gle;
    int lat, exp_lat;
    bit saw_done;
    logic [15:0] ra, rb;
    logic rs;

    rst = 1'b1;
    start_v = '0;
    sm_v = '0;
    for (int i = 0; i < 5; i++) begin a_v[i] = '0; b_v[i] = '0; end

    vecs[0]  = '{0, 16'h1234, 16'h1234, 1'b0, 3'b001, 4};
    vecs[1]  = '{0, 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    vecs[2]  = '{0, 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1};
    vecs[3]  = '{0, 16'hFFFF, 16'h0000, 1'b1, 3'b010, 1};
    vecs[4]  = '{0, 16'h8000, 16'h8000, 1'b1, 3'b001, 4};
    vecs[5]  = '{0, 16'h12F0, 16'h12E0, 1'b0, 3'b100, 3};
    vecs[6]  = '{1, 16'h12F0, 16'h12E0, 1'b0, 3'b100, 4};
    vecs[7]  = '{1, 16'h0001, 16'h0002, 1'b1, 3'b010, 4};
    vecs[8]  = '{4, 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1};
    vecs[9]  = '{4, 16'h0005, 16'h0005, 1'b0, 3'b001, 1};
    vecs[10] = '{2, 16'h12F0, 16'h12E0, 1'b0, 3'b100, 12};
    vecs[11] = '{3, 16'h00FF, 16'h0100, 1'b1, 3'b010, 8};
    vecs[12] = '{2, 16'hFFFF, 16'hFFFE, 1'b0, 3'b100, 16};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_busy[%0d]", i), int'(busy_v[i]), 0);
      check($sformatf("rst_done[%0d]", i), int'(done_v[i]), 0);
      check($sformatf("rst_gle[%0d]", i), int'(gle_of(i)), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Fixed vectors
    for (int v = 0; v < 13; v++) begin
      do_compare(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sm, gle, lat);
      check($sformatf("vec%0d_gle", v), int'(gle), int'(vecs[v].gle));
      check($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
    end

    // Continuous start with changing operands
    for (int i = 0; i < 2; i++) begin
      do_compare(i, 16'h0000, 16'h0000, 1'b0, gle, lat);
      check($sformatf("hs_pre_gle[%0d]", i), int'(gle), 3'b001);
      handshake(i, 3'b001);
    end

    // Reset in the middle of a compare; start held across reset release
    @(negedge clk);
    a_v[0] = 16'h0001; b_v[0] = 16'h0002; sm_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy_v[0]), 0);
    check("midrst_done", int'(done_v[0]), 0);
    check("midrst_gle", int'(gle_of(0)), 0);
    check("midrst_gle_d16", int'(gle_of(4)), 0);
    a_v[4] = 16'd7; b_v[4] = 16'd9; sm_v[4] = 1'b0; start_v[4] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("held_start_busy", int'(busy_v[4]), 1);
    @(negedge clk);
    start_v[4] = 1'b0;
    @(posedge clk); #1;
    check("held_start_done", int'(done_v[4]), 1);
    check("held_start_gle", int'(gle_of(4)), 3'b010);
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) saw_done = 1'b1;
    end
    check("midrst_no_done", int'(saw_done), 0);
    check("midrst_gle_after", int'(gle_of(0)), 0);
    do_compare(0, 16'd5, 16'd3, 1'b0, gle, lat);
    check("post_rst_gle", int'(gle), 3'b100);
    check("post_rst_lat", lat, 4);

    // Random sweep over every instance against the reference model
    for (int i = 0; i < 5; i++) begin
      for (int t = 0; t < 25; t++) begin
        ra = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
          default: rb = 16'($urandom);
        endcase
        rs = 1'($urandom);
        model(i, ra, rb, rs, exp_gle, exp_lat);
        do_compare(i, ra, rb, rs, gle, lat);
        check($sformatf("rnd[%0d] %h/%h s%0d gle", i, ra, rb, rs), int'(gle), int'(exp_gle));
        check($sformatf("rnd[%0d] %h/%h s%0d lat", i, ra, rb, rs), lat, exp_lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/comparator_serial.md
# comparator_serial

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement signed mode. Results are registered G/L/E flags with a start/busy/done handshake, and an optional early exit on the first differing digit. It replaces the fixed 4-bit combinational comparator wherever wide operands would otherwise create a long compare path.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per clock; 1 ≤ DIGIT ≤ WIDTH.
- EARLY, 1, controls when a result is reported:
  - 1: report on the first unequal digit.
  - 0: always take N = WIDTH/DIGIT cycles (constant latency).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
- A  in  WIDTH  operand A; captured at start.
- B  in  WIDTH  operand B; captured at start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when G/L/E update.
- G  out  1  A > B.
- L  out  1  A < B.
- E  out  1  A == B.

## Operation
- States: IDLE, BUSY.
- IDLE to BUSY happens on start=1. At that edge the block:
  - loads shift registers SA and SB from A and B;
  - inverts the MSB of both when signed_mode=1 (offset-binary mapping, so a signed compare becomes an unsigned compare);
  - clears digit counter cnt to 0, clears the internal decided flag and its latched result, and sets busy=1.
- BUSY, each cycle, compares the top DIGIT bits of SA and SB (unsigned):
  - If unequal and no decision is latched yet, latch G or L.
  - If EARLY=1, that first inequality also finishes the operation.
  - If equal, shift SA and SB left by DIGIT and increment cnt.
  - At cnt = N−1 the operation finishes regardless. Result: the latched G or L if a decision exists, otherwise E.
  - With EARLY=0, digits after the first inequality are still stepped but never change the latched result.
- Finish edge: G/L/E take the result, done=1 for one cycle, busy=0, state returns to IDLE.
- Exactly one of G/L/E is high after the first done.
- G/L/E hold their value until the next finish edge. Accepting a new start does not clear them.
- start is ignored while in BUSY, including when held high.
- A, B and signed_mode are not sampled after the start edge, so they may change freely while BUSY.
- cnt width is clog2(N) with a minimum of 1. cnt never wraps, because BUSY always exits at N−1.
- Elaboration must fail (generate-time error) if WIDTH % DIGIT ≠ 0 or DIGIT > WIDTH.

## Timing
- Reset values (asynchronous, immediate, independent of clk): state=IDLE, busy=0, done=0, G=0, L=0, E=0, cnt=0.
- G/L/E are all 0 only between reset and the first done.
- Latency: start accepted at edge t0; the digit at index k (k=0 is the MSB digit) is evaluated in the cycle after edge t0+k; result and done appear at edge t0+m.
  - EARLY=1: m = 1 + index of the first differing digit, or N if the operands are equal.
  - EARLY=0: m = N always.
- busy is high from edge t0 up to edge t0+m; it falls at the same edge that done rises.
- Back-to-back operation: start may be asserted in the done cycle, where the state is already IDLE.
  - It is accepted at the next edge, giving a throughput of one compare per m+1 cycles.
  - done does not re-pulse until the next finish.
- Reset mid-operation: busy, done and G/L/E clear at once. The in-flight compare is discarded and no done follows.
- A start held high across reset release is accepted at the first clock edge after rst falls.
- N=1 (DIGIT=WIDTH): single-cycle compare; done appears at t0+1.

## Test plan
- Equal: WIDTH=16, DIGIT=4, EARLY=1, unsigned, A=0x1234, B=0x1234. Required: E=1, G=L=0, done exactly one cycle, 4 cycles after the start edge, busy high for 4 cycles.
- Sign handling: A=0x8000, B=0x7FFF. Unsigned gives G=1 at latency 1. Signed gives L=1 at latency 1. Signed A=0xFFFF, B=0x0000 gives L=1. Signed A=0x8000, B=0x8000 gives E=1 at latency 4.
- Early vs fixed latency: A=0x12F0, B=0x12E0. EARLY=1 gives G=1 at latency 3. EARLY=0 gives G=1 at latency 4, and the later digits (0 vs 0) must not overwrite the result.
- Handshake: hold start=1 continuously with new A/B each cycle. Only IDLE-cycle values are captured. Consecutive done pulses are m+1 cycles apart, and G/L/E hold between them.
- Reset mid-op: A=0x0001, B=0x0002 (EARLY=1); assert rst asynchronously between clock edges 2 cycles after start. Required: busy, done, G, L, E go to 0 immediately and no done follows. After release, a new compare of 5 vs 3 gives G=1.
- Parameter sweep: DIGIT=1, 2, 16 with WIDTH=16. Random signed and unsigned operand pairs must match a reference model, with latency within the stated bounds.
